flash_ctrl: RTL and testbench

FLASH_CTRL -- requirements
Module: flash_ctrl

---
 rtl/flash_ctrl_if.sv | 28 ++
 rtl/flash_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_flash_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_ctrl_if.sv
// Host-side request/response bus of the parallel NOR flash controller.
interface flash_ctrl_if #(
    parameter int FLASH_ADDR_SIZE = 22
);
    // Handshake: req_read/req_write/req_erase are one-cycle strobes, taken only while
    // busy=0 and done=0; busy then stays high through the done cycle, and done pulses
    // for exactly one cycle with data_out, err and err_code valid.
    logic [FLASH_ADDR_SIZE-1:0] addr;
    logic [15:0]                data_in;
    logic                       req_read;
    logic                       req_write;
    logic                       req_erase;
    logic [15:0]                data_out;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [3:0]                 err_code;

    modport master (
        output addr, data_in, req_read, req_write, req_erase,
        input  data_out, busy, done, err, err_code
    );

    modport slave (
        input  addr, data_in, req_read, req_write, req_erase,
        output data_out, busy, done, err, err_code
    );
endinterface

// File: rtl/flash_ctrl.sv
// Command sequencer for a 16-bit parallel NOR flash: array read, word program and
// block erase with status polling, error clear and poll timeout.
module flash_ctrl #(
    parameter int FLASH_ADDR_SIZE = 22,
    parameter int WE_PULSE        = 2,
    parameter int READ_WAIT       = 4,
    parameter int POLL_LIMIT      = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    flash_ctrl_if.slave              bus,
    output logic [FLASH_ADDR_SIZE:0] flash_addr,
    inout  wire  [15:0]              flash_data,
    output logic [7:0]               flash_ctl,
    output logic [3:0]               dbg_state
);
    localparam int PCW = $clog2(POLL_LIMIT) + 1;

    typedef enum logic [3:0] {
        IDLE, CMD_LO, CMD_HI, DAT_LO, DAT_HI, RD_WAIT, SR_CMD_LO,
        SR_CMD_HI, SR_WAIT, SR_EVAL, CLR_LO, CLR_HI, DONE
    } state_e;

    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ERASE} op_e;

    state_e                     state_q, state_d;
    op_e                        op_q, op_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [PCW-1:0]             poll_q, poll_d;
    logic [FLASH_ADDR_SIZE-1:0] addr_q, addr_d;
    logic [15:0]                wdata_q, wdata_d;
    logic [15:0]                rdata_q, rdata_d;
    logic                       array_q, array_d;
    logic                       err_q, err_d;
    logic [3:0]                 code_q, code_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic        accept;
    logic        pulse_last;
    logic        wait_last;
    logic        drive;
    logic        we_n;
    logic        oe_n;
    logic [15:0] bus_word;
    logic [15:0] cmd_word;

    // done is registered from the DONE state, so IDLE must also refuse strobes while it is high.
    assign accept     = (state_q == IDLE) && !done_q &&
                        (bus.req_read || bus.req_write || bus.req_erase);
    assign pulse_last = (cnt_q == 4'(WE_PULSE - 1));
    assign wait_last  = (cnt_q == 4'(READ_WAIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            cnt_q   <= '0;
            poll_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            array_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            poll_q  <= poll_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            array_q <= array_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = '0;
        poll_d  = poll_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        array_d = array_q;
        err_d   = err_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = bus.addr;
                    err_d  = 1'b0;
                    code_d = '0;
                    poll_d = '0;
                    if (bus.req_write) begin
                        op_d    = OP_WRITE;
                        wdata_d = bus.data_in;
                        state_d = CMD_LO;
                    end else if (bus.req_erase) begin
                        op_d    = OP_ERASE;
                        wdata_d = 16'h00D0;
                        state_d = CMD_LO;
                    end else begin
                        op_d    = OP_READ;
                        state_d = array_q ? RD_WAIT : CMD_LO;
                    end
                end
            end
            CMD_LO:    if (pulse_last) state_d = CMD_HI; else cnt_d = cnt_q + 4'd1;
            CMD_HI:    state_d = (op_q == OP_READ) ? RD_WAIT : DAT_LO;
            DAT_LO:    if (pulse_last) state_d = DAT_HI; else cnt_d = cnt_q + 4'd1;
            DAT_HI:    state_d = SR_CMD_LO;
            RD_WAIT: begin
                if (wait_last) begin
                    rdata_d = flash_data;
                    array_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SR_CMD_LO: if (pulse_last) state_d = SR_CMD_HI; else cnt_d = cnt_q + 4'd1;
            SR_CMD_HI: state_d = SR_WAIT;
            SR_WAIT:   if (wait_last) state_d = SR_EVAL; else cnt_d = cnt_q + 4'd1;
            SR_EVAL: begin
                if (flash_data[7]) begin
                    array_d = 1'b0;
                    if (flash_data[5:3] != 3'b000) begin
                        err_d   = 1'b1;
                        code_d  = {1'b0, flash_data[5:3]};
                        state_d = CLR_LO;
                    end else begin
                        state_d = DONE;
                    end
                end else if (poll_q == PCW'(POLL_LIMIT - 1)) begin
                    // Give up: the closing 0x00FF leaves the part in read-array mode.
                    err_d   = 1'b1;
                    code_d  = 4'b1000;
                    array_d = 1'b1;
                    state_d = CLR_LO;
                end else begin
                    poll_d  = poll_q + PCW'(1);
                    state_d = SR_CMD_LO;
                end
            end
            CLR_LO:    if (pulse_last) state_d = CLR_HI; else cnt_d = cnt_q + 4'd1;
            CLR_HI:    state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE) || (state_q == DONE);
        done_d = (state_q == DONE);
    end

    always_comb begin
        cmd_word = 16'h00FF;
        unique case (op_q)
            OP_WRITE: cmd_word = 16'h0040;
            OP_ERASE: cmd_word = 16'h0020;
            default:  cmd_word = 16'h00FF;
        endcase
    end

    // The data bus is only driven across a we-low pulse and its trailing we-high cycle.
    always_comb begin
        drive    = 1'b0;
        bus_word = 16'h0000;
        unique case (state_q)
            CMD_LO, CMD_HI: begin
                drive    = 1'b1;
                bus_word = cmd_word;
            end
            DAT_LO, DAT_HI: begin
                drive    = 1'b1;
                bus_word = wdata_q;
            end
            SR_CMD_LO, SR_CMD_HI: begin
                drive    = 1'b1;
                bus_word = 16'h0070;
            end
            CLR_LO, CLR_HI: begin
                drive    = 1'b1;
                bus_word = code_q[3] ? 16'h00FF : 16'h0050;
            end
            default: ;
        endcase
    end

    assign we_n = !(state_q inside {CMD_LO, DAT_LO, SR_CMD_LO, CLR_LO});
    assign oe_n = !(state_q inside {RD_WAIT, SR_WAIT, SR_EVAL});

    assign flash_data = drive ? bus_word : 16'hzzzz;
    assign flash_addr = {addr_q, 1'b0};
    assign flash_ctl  = {1'b1, 1'b0, 2'b00, oe_n, 1'b1, 1'b1, we_n};
    assign dbg_state  = state_q;

    assign bus.data_out = rdata_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.err_code = code_q;
endmodule

// File: tb/tb_flash_ctrl.sv
// Directed and randomized bench for flash_ctrl against a behavioural NOR flash model.
module tb_flash_ctrl;
    localparam int FAS        = 22;
    localparam int WE_PULSE   = 2;
    localparam int READ_WAIT  = 4;
    localparam int POLL_LIMIT = 4;
    localparam int K_READ     = 0;
    localparam int K_WRITE    = 1;
    localparam int K_ERASE    = 2;

    logic         clk;
    logic         rst_n;
    wire  [15:0]  flash_data;
    logic [FAS:0] flash_addr;
    logic [7:0]   flash_ctl;
    logic [3:0]   dbg_state;

    flash_ctrl_if #(.FLASH_ADDR_SIZE(FAS)) bus_if ();

    flash_ctrl #(
        .FLASH_ADDR_SIZE(FAS),
        .WE_PULSE       (WE_PULSE),
        .READ_WAIT      (READ_WAIT),
        .POLL_LIMIT     (POLL_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .flash_addr(flash_addr),
        .flash_data(flash_data),
        .flash_ctl (flash_ctl),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Flash model and bus monitor
    int          checks = 0;
    int          failures = 0;
    int          overlap_cnt = 0;
    logic [15:0] flash_drv = 16'h0000;
    logic [15:0] sr_q[$];
    logic [15:0] wr_log[$];
    logic [FAS:0] addr_log[$];
    logic [15:0] mem [int unsigned];
    bit          status_mode = 1'b0;
    bit          cmd_pending = 1'b0;
    bit          exp_array = 1'b0;
    logic        we_prev = 1'b1;
    logic        oe_prev = 1'b1;
    logic [15:0] last_rd_data = 16'h0000;

    assign flash_data = flash_ctl[3] ? 16'hzzzz : flash_drv;

    function automatic logic [15:0] mem_val(input logic [FAS-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            we_prev = 1'b1;
            oe_prev = 1'b1;
        end else begin
            if (!flash_ctl[3] && !flash_ctl[0]) overlap_cnt++;
            if (!we_prev && flash_ctl[0]) begin
                wr_log.push_back(flash_data);
                addr_log.push_back(flash_addr);
                if (cmd_pending) begin
                    cmd_pending = 1'b0;
                    status_mode = 1'b1;
                end else begin
                    case (flash_data)
                        16'h00FF: status_mode = 1'b0;
                        16'h0070: status_mode = 1'b1;
                        16'h0040, 16'h0020: cmd_pending = 1'b1;
                        default: ;
                    endcase
                end
            end
            if (oe_prev && !flash_ctl[3]) begin
                if (!status_mode) flash_drv = mem_val(flash_addr[FAS:1]);
                else if (sr_q.size() > 0) flash_drv = sr_q.pop_front();
                else flash_drv = 16'h0080;
            end
            we_prev = flash_ctl[0];
            oe_prev = flash_ctl[3];
        end
    end

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: one host operation plus its expected bus-write list built from the command rules.
    task automatic run_op(input string tag, input int kind, input logic [FAS-1:0] a,
                          input logic [15:0] d, input bit collide);
        logic [15:0] exp_q[$];
        logic [15:0] plan[$];
        logic [15:0] sr;
        logic [15:0] exp_data;
        logic        exp_err;
        logic [3:0]  exp_code;
        int          exp_lat;
        int          n;
        plan     = sr_q;
        exp_err  = 1'b0;
        exp_code = 4'h0;
        exp_lat  = 0;
        exp_data = 16'h0000;
        if (kind == K_READ) begin
            if (!exp_array) exp_q.push_back(16'h00FF);
            exp_lat   = 1 + (exp_array ? 0 : WE_PULSE + 1) + READ_WAIT + 1;
            exp_data  = mem_val(a);
            exp_array = 1'b1;
        end else begin
            exp_q.push_back(kind == K_WRITE ? 16'h0040 : 16'h0020);
            exp_q.push_back(kind == K_WRITE ? d : 16'h00D0);
            exp_array = 1'b0;
            for (int i = 0; i < POLL_LIMIT; i++) begin
                exp_q.push_back(16'h0070);
                sr = (plan.size() > 0) ? plan[0] : 16'h0080;
                if (plan.size() > 0) plan.delete(0);
                if (sr[7]) begin
                    if (sr[5:3] != 3'b000) begin
                        exp_err  = 1'b1;
                        exp_code = {1'b0, sr[5:3]};
                        exp_q.push_back(16'h0050);
                    end
                    break;
                end else if (i == POLL_LIMIT - 1) begin
                    exp_err   = 1'b1;
                    exp_code  = 4'b1000;
                    exp_array = 1'b1;
                    exp_q.push_back(16'h00FF);
                end
            end
        end

        @(posedge clk); #1;
        wr_log = {};
        addr_log = {};
        bus_if.addr      = a;
        bus_if.data_in   = d;
        bus_if.req_read  = (kind == K_READ) || collide;
        bus_if.req_write = (kind == K_WRITE);
        bus_if.req_erase = (kind == K_ERASE);
        @(posedge clk); #1;
        n = 1;
        bus_if.req_read  = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_erase = 1'b0;
        check({tag, "_busy_c1"}, bus_if.busy, 1'b1);
        while (!bus_if.done && n < 500) begin
            bus_if.req_read = collide && (n == 3);
            @(posedge clk); #1;
            n++;
        end
        bus_if.req_read = 1'b0;
        check({tag, "_done_seen"}, bus_if.done, 1'b1);
        if (!bus_if.done) begin
            sr_q = {};
            return;
        end
        check({tag, "_busy_done"}, bus_if.busy, 1'b1);
        check({tag, "_err"}, bus_if.err, exp_err);
        check({tag, "_code"}, bus_if.err_code, exp_code);
        if (kind == K_READ) begin
            check({tag, "_lat"}, n, exp_lat);
            check({tag, "_data"}, bus_if.data_out, exp_data);
            last_rd_data = exp_data;
        end
        // A strobe on the done cycle must be dropped.
        bus_if.addr     = 22'($urandom);
        bus_if.req_read = 1'b1;
        @(posedge clk); #1;
        bus_if.req_read = 1'b0;
        check({tag, "_idle_busy"}, bus_if.busy, 1'b0);
        check({tag, "_idle_done"}, bus_if.done, 1'b0);
        check({tag, "_nwr"}, wr_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
            check({tag, "_wr"}, wr_log[i], exp_q[i]);
            check({tag, "_wa"}, addr_log[i], {a, 1'b0});
        end
        sr_q = {};
    endtask

    // Stimulus
    initial begin
        int          kind;
        int          npoll;
        logic [FAS-1:0] ra;
        logic [15:0] rd;
        rst_n            = 1'b0;
        bus_if.addr      = '0;
        bus_if.data_in   = '0;
        bus_if.req_read  = 1'b0;
        bus_if.req_write = 1'b0;
        bus_if.req_erase = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_busy", bus_if.busy, 1'b0);
        check("rst_done", bus_if.done, 1'b0);
        check("rst_err", bus_if.err, 1'b0);
        check("rst_code", bus_if.err_code, 4'h0);
        check("rst_data", bus_if.data_out, 16'h0000);
        check("rst_ctl", flash_ctl, 8'h8F);
        @(negedge clk) rst_n = 1'b1;

        mem[32'h10] = 16'hBEEF;
        run_op("rd_first", K_READ, 22'h000010, 16'h0000, 1'b0);
        mem[32'h11] = 16'($urandom);
        run_op("rd_array", K_READ, 22'h000011, 16'h0000, 1'b0);

        sr_q = {16'h0000, 16'h0000, 16'h0000, 16'h0080};
        run_op("wr_poll", K_WRITE, 22'h000123, 16'h5A5A, 1'b0);
        mem[32'h20] = 16'h1234;
        run_op("rd_after_wr", K_READ, 22'h000020, 16'h0000, 1'b0);

        sr_q = {16'h00A0};
        run_op("erase_err", K_ERASE, 22'h03F000, 16'h0000, 1'b0);

        sr_q = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_op("wr_tmo", K_WRITE, 22'h000456, 16'hC3C3, 1'b0);

        // Abort a read while oe is low.
        @(posedge clk); #1;
        bus_if.addr     = 22'h000ABC;
        bus_if.req_read = 1'b1;
        @(posedge clk); #1;
        bus_if.req_read = 1'b0;
        @(posedge clk); #1;
        check("abort_oe_low", flash_ctl[3], 1'b0);
        rst_n = 1'b0;
        #1;
        check("abort_oe", flash_ctl[3], 1'b1);
        check("abort_we", flash_ctl[0], 1'b1);
        check("abort_busy", bus_if.busy, 1'b0);
        check("abort_done", bus_if.done, 1'b0);
        check("abort_data", bus_if.data_out, 16'h0000);
        check("abort_code", bus_if.err_code, 4'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        exp_array   = 1'b0;
        cmd_pending = 1'b0;
        run_op("rd_post_rst", K_READ, 22'h000010, 16'h0000, 1'b0);

        sr_q = {16'h0000, 16'h0080};
        run_op("wr_collide", K_WRITE, 22'h000777, 16'h0F0F, 1'b1);

        for (int t = 0; t < 16; t++) begin
            kind = $urandom_range(0, 2);
            ra   = 22'($urandom);
            rd   = 16'($urandom);
            if (kind == K_READ) begin
                mem[int'(ra)] = 16'($urandom);
            end else begin
                npoll = $urandom_range(0, POLL_LIMIT - 1);
                for (int p = 0; p < npoll; p++) sr_q.push_back(16'($urandom_range(0, 127)));
                if ($urandom_range(0, 4) == 0) begin
                    for (int p = npoll; p < POLL_LIMIT; p++) sr_q.push_back(16'($urandom_range(0, 127)));
                end else if ($urandom_range(0, 1) == 0) begin
                    sr_q.push_back(16'h0080 | 16'($urandom_range(0, 7)) | 16'h0040);
                end else begin
                    sr_q.push_back(16'h0080 | 16'($urandom_range(0, 63)));
                end
            end
            run_op("rand", kind, ra, rd, 1'b0);
        end

        check("oe_we_overlap", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
